// File: rtl/alu_pkg.sv
// Shared definitions for the ALU add/subtract datapath: operation encoding
// and the legal pipeline-depth check used by addsub_pipe.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ADC = 2'd2,
        OP_SBC = 2'd3
    } addsub_op_t;

    // Bit s set means STAGES = s is a legal pipeline depth (1, 2, 4, 8).
    localparam logic [15:0] ADDSUB_LEGAL_STAGES_MASK = 16'b0000_0001_0001_0110;

    function automatic logic addsub_stages_legal(input int unsigned s);
        logic [3:0] idx;
        idx = s[3:0];
        return (s >= 1 && s <= 8) ? ADDSUB_LEGAL_STAGES_MASK[idx] : 1'b0;
    endfunction

endpackage

// File: rtl/addsub_segment.sv
// One SW-bit slice of the pipelined carry chain; purely combinational,
// the stage registers around it live in addsub_pipe.
module addsub_segment #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          c_i,
    output logic [SW-1:0] s_o,
    output logic          c_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, c_i};

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit with valid/ready on both sides and a global stall.
// Optional macro ADDSUB_SATURATE_EN clamps the result to the signed limit on overflow.
module addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] Rb,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int SW = WIDTH / STAGES;

    if (!addsub_stages_legal(STAGES) || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("addsub_pipe: illegal WIDTH/STAGES combination");
    end

    // Stage k register holds the operands, the finished low sum bits and the
    // carry into segment k; segment k's result moves on to stage k+1.
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0]            v_q, v_d;

    logic [STAGES-1:0][SW-1:0]    seg_s;
    logic [STAGES-1:0]            seg_c;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;

    addsub_op_t       op_e;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [WIDTH-1:0] fin_sum;
    logic [WIDTH-1:0] res;
    logic             a_msb, b_msb, ovf;
    logic             stall;

    assign op_e  = addsub_op_t'(op);
    assign stall = out_valid_q && !out_ready;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_seg
        addsub_segment #(.SW(SW)) u_seg (
            .a_i (a_q[gi][gi*SW +: SW]),
            .b_i (b_q[gi][gi*SW +: SW]),
            .c_i (c_q[gi]),
            .s_o (seg_s[gi]),
            .c_o (seg_c[gi])
        );
    end

    always_comb begin
        b_in = (op_e == OP_SUB || op_e == OP_SBC) ? ~Rb : Rb;
        case (op_e)
            OP_ADD:  c_in = 1'b0;
            OP_SUB:  c_in = 1'b1;
            default: c_in = cin;
        endcase
    end

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        s_d = s_q;
        c_d = c_q;
        v_d = v_q;

        a_d[0] = Ra;
        b_d[0] = b_in;
        s_d[0] = '0;
        c_d[0] = c_in;
        v_d[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]                  = a_q[k-1];
            b_d[k]                  = b_q[k-1];
            s_d[k]                  = s_q[k-1];
            s_d[k][(k-1)*SW +: SW]  = seg_s[k-1];
            c_d[k]                  = seg_c[k-1];
            v_d[k]                  = v_q[k-1];
        end

        fin_sum                          = s_q[STAGES-1];
        fin_sum[(STAGES-1)*SW +: SW]     = seg_s[STAGES-1];
        a_msb = a_q[STAGES-1][WIDTH-1];
        b_msb = b_q[STAGES-1][WIDTH-1];
        ovf   = (a_msb == b_msb) && (fin_sum[WIDTH-1] != a_msb);

        res = fin_sum;
`ifdef ADDSUB_SATURATE_EN
        if (ovf) begin
            res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif

        out_valid_d = v_q[STAGES-1];
        sum_d       = res;
        cout_d      = seg_c[STAGES-1];
        overflow_d  = ovf;
        zero_d      = (res == '0);
        negative_d  = fin_sum[WIDTH-1];
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            c_q         <= '0;
            v_q         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
        end else if (!stall) begin
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            c_q         <= c_d;
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
        end
    end

    // The last stage only consumes its own segment and the operand MSBs.
    logic unused_last_stage;
    assign unused_last_stage = ^{a_q[STAGES-1], b_q[STAGES-1], s_q[STAGES-1]};

    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed testbench for addsub_pipe (WIDTH=32, STAGES=4); a negedge monitor
// checks every presented result against a queue of hand-computed expectations.
module tb_addsub_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    typedef struct {
        vec_t vec;
        int   acc;
    } exp_t;

    logic              clock;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [WIDTH-1:0]  ra;
    logic [WIDTH-1:0]  rb;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic              overflow;
    logic              zero;
    logic              negative;

    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   n_out = 0;
    bit   lat_chk = 0;
    exp_t sb[$];
    vec_t vecs[12];

    addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clock     (clock),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .Ra        (ra),
        .Rb        (rb),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Result monitor: every presented result is compared, including while stalled.
    always @(negedge clock) begin
        if (!clear && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out", {63'd0, out_valid}, 64'd0);
            end else begin
                check("sum",      {32'd0, sum},        {32'd0, sb[0].vec.s});
                check("cout",     {63'd0, cout},       {63'd0, sb[0].vec.c});
                check("overflow", {63'd0, overflow},   {63'd0, sb[0].vec.v});
                check("zero",     {63'd0, zero},       {63'd0, sb[0].vec.z});
                check("negative", {63'd0, negative},   {63'd0, sb[0].vec.n});
                if (out_ready) begin
                    if (lat_chk) check("latency", 64'(cyc - sb[0].acc), 64'(STAGES));
                    $display("[TB] result %0d: sum=%08h cout=%0b ovf=%0b z=%0b n=%0b",
                             n_out, sum, cout, overflow, zero, negative);
                    void'(sb.pop_front());
                    n_out++;
                end
            end
        end
        if (out_valid && !out_ready) check("in_ready_stall", {63'd0, in_ready}, 64'd0);
    end

    task automatic send(input vec_t v, input bit keep);
        int waitc;
        exp_t e;
        waitc    = 0;
        in_valid = 1'b1;
        op       = v.op;
        ra       = v.a;
        rb       = v.b;
        cin      = v.ci;
        @(negedge clock);
        while (!in_ready && waitc < 50) begin
            waitc++;
            @(negedge clock);
        end
        check("accept", {63'd0, in_ready}, 64'd1);
        if (in_ready && keep) begin
            e.vec = v;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int waitc;
        waitc = 0;
        while (sb.size() != 0 && waitc < 40) begin
            waitc++;
            @(negedge clock);
        end
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          op     a             b             ci    sum           c     v     z     n
        vecs[0]  = '{2'd1, 32'd235,      32'd35,       1'b0, 32'd200,      1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'd1, 32'd20,       32'd25,       1'b0, 32'hFFFFFFFB, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{2'd1, 32'd1,        32'd1,        1'b0, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0};
`ifdef ADDSUB_SATURATE_EN
        vecs[3]  = '{2'd0, 32'h7FFFFFFF, 32'd1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        vecs[3]  = '{2'd0, 32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        vecs[4]  = '{2'd0, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{2'd2, 32'd0,        32'd0,        1'b1, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{2'd3, 32'd5,        32'd3,        1'b0, 32'd1,        1'b1, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SATURATE_EN
        vecs[7]  = '{2'd1, 32'h80000000, 32'd1,        1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        vecs[7]  = '{2'd1, 32'h80000000, 32'd1,        1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        vecs[8]  = '{2'd2, 32'hFFFFFFFF, 32'd0,        1'b1, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{2'd3, 32'd0,        32'd0,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{2'd0, 32'h0000FFFF, 32'd1,        1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{2'd0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0, 1'b1};

        clear     = 1'b1;
        in_valid  = 1'b0;
        op        = 2'd0;
        ra        = '0;
        rb        = '0;
        cin       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum",       {32'd0, sum},       64'd0);
        check("rst_flags",     {60'd0, cout, overflow, zero, negative}, 64'd0);
        @(posedge clock);
        #1;
        clear = 1'b0;
        @(negedge clock);
        check("in_ready_after_rst", {63'd0, in_ready}, 64'd1);
        @(posedge clock);
        #1;

        // Directed vectors back-to-back at full throughput
        lat_chk = 1'b1;
        for (int i = 0; i < 12; i++) send(vecs[i], 1'b1);
        in_valid = 1'b0;
        drain();

        // Backpressure: out_ready low for 3 cycles mid-stream
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(vecs[i], 1'b1);
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clock);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with 3 beats in flight plus a beat offered during clear
        for (int i = 0; i < 3; i++) send(vecs[i], 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        op       = vecs[4].op;
        ra       = vecs[4].a;
        rb       = vecs[4].b;
        cin      = vecs[4].ci;
        @(negedge clock);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clock);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        repeat (10) @(negedge clock);
        check("flush_no_stale", {63'd0, out_valid}, 64'd0);
        @(posedge clock);
        #1;

        // Fresh beat after reset
        lat_chk = 1'b1;
        send(vecs[11], 1'b1);
        in_valid = 1'b0;
        drain();

        check("results_total", 64'(n_out), 64'd21);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
